// File: rtl/interpol_3_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// interpol_3_pipe: G.729 Interpol_3 1/3-resolution FIR interpolator
// with bench-loadable scratch RAM and inter_3 coefficient ROM. Rev 1.0
// ------------------------------------------------------------------
module interpol_3_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] x,
  input  logic [15:0] frac,
  input  logic [11:0] inter_3,
  input  logic [11:0] TBwriteAddrScratch,
  input  logic [31:0] TBwriteDataScratch,
  input  logic        TBwriteEnScratch,
  output logic [15:0] returnS,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADJ   = 3'd1,
    S_FETCH = 3'd2,
    S_MAC   = 3'd3,
    S_ROUND = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [11:0]        x_q, x_d;
  logic [15:0]        frac_q, frac_d;
  logic [11:0]        inter3_q, inter3_d;
  logic [11:0]        base_q, base_d;
  logic [11:0]        f_q, f_d;
  logic [2:0]         step_q, step_d;
  logic signed [31:0] acc_q, acc_d;
  logic [15:0]        ret_q, ret_d;
  logic               done_q, done_d;

  logic [31:0]        mem [4096];
  logic [31:0]        ram_rd_q;
  logic [15:0]        rom_rd_q;

  logic [11:0]        w_i, w_i3, w_ram_addr, w_rom_addr;
  logic [15:0]        w_fracp3;
  logic signed [31:0] w_rnd;
  logic               w_unused;

  function automatic logic signed [31:0] l_add(input logic signed [31:0] a,
                                               input logic signed [31:0] b);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    return s[31:0];
  endfunction

  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (a == -16'sd32768 && b == -16'sd32768)
      return 32'sh7FFF_FFFF;
    return {p[30:0], 1'b0};
  endfunction

  function automatic logic [15:0] rom_word(input logic [11:0] a);
    case (a)
      12'd3952: return 16'd29443;
      12'd3953: return 16'd25207;
      12'd3954: return 16'd14701;
      12'd3955: return 16'd3143;
      12'd3956: return -16'sd4402;
      12'd3957: return -16'sd5850;
      12'd3958: return -16'sd2783;
      12'd3959: return 16'd1211;
      12'd3960: return 16'd3130;
      12'd3961: return 16'd2259;
      12'd3962: return 16'd0;
      12'd3963: return -16'sd1652;
      12'd3964: return -16'sd1666;
      default:  return 16'd0;
    endcase
  endfunction

  // Step bit 0 selects the x2/c2 half of iteration i = step[2:1].
  assign w_i        = {10'd0, step_q[2:1]};
  assign w_i3       = w_i + w_i + w_i;
  assign w_ram_addr = step_q[0] ? (base_q + 12'd1 + w_i) : (base_q - w_i);
  assign w_rom_addr = step_q[0] ? (inter3_q + (12'd3 - f_q) + w_i3)
                                : (inter3_q + f_q + w_i3);
  assign w_fracp3   = frac_q + 16'd3;
  assign w_rnd      = l_add(acc_q, 32'sd32768);
  assign w_unused   = ^{frac_q[14:12], w_fracp3[15:12], ram_rd_q[31:16], w_rnd[15:0]};

  always_ff @(posedge clk) begin
    if (TBwriteEnScratch)
      mem[TBwriteAddrScratch] <= TBwriteDataScratch;
    ram_rd_q <= mem[w_ram_addr];
    rom_rd_q <= rom_word(w_rom_addr);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    frac_d   = frac_q;
    inter3_d = inter3_q;
    base_d   = base_q;
    f_d      = f_q;
    step_d   = step_q;
    acc_d    = acc_q;
    ret_d    = ret_q;
    done_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d      = x;
          frac_d   = frac;
          inter3_d = inter_3;
          state_d  = S_ADJ;
        end
      end
      S_ADJ: begin
        f_d     = frac_q[15] ? w_fracp3[11:0] : frac_q[11:0];
        base_d  = frac_q[15] ? (x_q - 12'd1) : x_q;
        acc_d   = 32'sd0;
        step_d  = 3'd0;
        state_d = S_FETCH;
      end
      S_FETCH: state_d = S_MAC;
      S_MAC: begin
        // Saturate after every MAC; the order of accumulation matters.
        acc_d   = l_add(acc_q, l_mult($signed(ram_rd_q[15:0]), $signed(rom_rd_q)));
        step_d  = step_q + 3'd1;
        state_d = (step_q == 3'd7) ? S_ROUND : S_FETCH;
      end
      S_ROUND: begin
        ret_d   = w_rnd[31:16];
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= 12'd0;
      frac_q   <= 16'd0;
      inter3_q <= 12'd0;
      base_q   <= 12'd0;
      f_q      <= 12'd0;
      step_q   <= 3'd0;
      acc_q    <= 32'sd0;
      ret_q    <= 16'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      frac_q   <= frac_d;
      inter3_q <= inter3_d;
      base_q   <= base_d;
      f_q      <= f_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      ret_q    <= ret_d;
      done_q   <= done_d;
    end
  end

  assign returnS = ret_q;
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_interpol_3_pipe.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_interpol_3_pipe: directed self-checking bench for interpol_3_pipe.
// Rev 1.0
// ------------------------------------------------------------------
module tb_interpol_3_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] x = 12'd0;
  logic [15:0] frac = 16'd0;
  logic [11:0] inter_3 = 12'd3952;
  logic [11:0] TBwriteAddrScratch = 12'd0;
  logic [31:0] TBwriteDataScratch = 32'd0;
  logic        TBwriteEnScratch = 1'b0;
  logic [15:0] returnS;
  logic        done;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  interpol_3_pipe dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .x                  (x),
    .frac               (frac),
    .inter_3            (inter_3),
    .TBwriteAddrScratch (TBwriteAddrScratch),
    .TBwriteDataScratch (TBwriteDataScratch),
    .TBwriteEnScratch   (TBwriteEnScratch),
    .returnS            (returnS),
    .done               (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    TBwriteAddrScratch = a;
    TBwriteDataScratch = d;
    TBwriteEnScratch   = 1'b1;
    @(negedge clk);
    TBwriteEnScratch   = 1'b0;
  endtask

  // Clears 4080..4095 and 0..47, covering every address the vectors touch.
  task automatic clear_ram();
    for (int a = 4080; a < 4096 + 48; a++)
      wr(12'(a), 32'd0);
  endtask

  task automatic run(input string tag, input logic [11:0] xa, input logic [15:0] fr,
                     input logic [15:0] exp, input bit glitch);
    int cyc;
    bit seen;
    x = xa; frac = fr; inter_3 = 12'd3952; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 40) begin
      if (done) seen = 1'b1;
      else begin
        // A start during the computation must be ignored.
        if (glitch && cyc == 5) begin start = 1'b1; frac = 16'd1; end
        else start = 1'b0;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, {31'd0, seen}, 32'd1);
    check({tag, "_val"}, {16'd0, returnS}, {16'd0, exp});
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_ret", {16'd0, returnS}, 32'd0);
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (done) seen = 1'b1; end
    check("no_start_no_done", {31'd0, seen}, 32'd0);

    clear_ram();
    run("zero", 12'd16, 16'd0, 16'h0000, 1'b0);

    wr(12'd16, 32'h0000_4000);
    run("imp_f0",  12'd16, 16'd0,      16'h3982, 1'b0);
    run("imp_f1",  12'd16, 16'd1,      16'h313C, 1'b0);
    run("imp_fm1", 12'd16, 16'hFFFF,   16'h313C, 1'b0);
    run("imp_fm2", 12'd16, 16'hFFFE,   16'h1CB7, 1'b0);

    wr(12'd16, 32'h0000_8000);
    run("neg_f0", 12'd16, 16'd0, 16'h8CFD, 1'b0);

    // Upper halfword of the RAM word must be ignored.
    wr(12'd15, 32'hABCD_1000);
    wr(12'd16, 32'h0000_2000);
    wr(12'd17, 32'h0000_1000);
    run("three_tap_glitch", 12'd16, 16'd0, 16'h1FD3, 1'b1);

    for (int a = 0; a < 32; a++) wr(12'(a), 32'h0000_7FFF);
    run("sat_order", 12'd16, 16'd0, 16'h7566, 1'b0);

    clear_ram();
    wr(12'd4095, 32'h0000_1000);
    run("addr_wrap", 12'd0, 16'd0, 16'h0189, 1'b0);

    clear_ram();
    wr(12'd16, 32'h0000_4000);
    run("pre_abort", 12'd16, 16'd0, 16'h3982, 1'b0);
    x = 12'd16; frac = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_ret", {16'd0, returnS}, 32'd0);
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done) seen = 1'b1; end
    check("abort_no_done", {31'd0, seen}, 32'd0);
    run("restart", 12'd16, 16'd0, 16'h3982, 1'b0);
    run("back2back", 12'd16, 16'd1, 16'h313C, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
